order_book_param: RTL and testbench
===================================

Name: order_book_param

Overview:
- Parametrised single-side limit order book: holds up to DEPTH resting orders and publishes the best order, with highest price for a bid book and lowest for an ask book.
- Sits between the feed/order decoder and the matching/strategy logic.
- Successor to the fixed-width, bid-only order book. Adds selectable side, configurable widths and depth, a replace operation, explicit status codes and an occupancy count.
- Deterministic, data-independent latency per request.

Parameters:
DEPTH, 256, number of order slots (>=2)
ID_W, 32, order id width
QTY_W, 32, quantity width
PRICE_W, 64, price width (unsigned)
IS_BID, 1, 1 = best is max price; 0 = best is min price

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
valid  input  1  request strobe; held high until ready pulses
order_id  input  ID_W  target order id
quantity  input  QTY_W  request quantity
price  input  PRICE_W  request price
req_type  input  3  100 ADD, 001 REDUCE, 010 CANCEL, 011 REPLACE, others invalid
best_order_id  output  ID_W  id of best resting order
best_quantity  output  QTY_W  quantity of best order
best_price  output  PRICE_W  price of best order
best_valid  output  1  book non-empty
count  output  $clog2(DEPTH+1)  resting order count
status  output  2  00 OK, 01 FULL, 10 NOT_FOUND, 11 BAD
ready  output  1  one-cycle completion pulse

Behaviour:
- Reset: all slots invalid. count=0, best_* =0, best_valid=0, status=00, ready=0, FSM=IDLE. Reset asserted mid-request aborts the request, clears the book and produces no ready pulse.
- Storage: DEPTH slots, each holding {valid, id, qty, price}.
- FSM: IDLE -> SCAN -> UPDATE -> BEST -> DONE -> IDLE.
- IDLE: on a clk edge with valid=1, latch order_id, quantity, price and req_type, then go to SCAN.
- SCAN: DEPTH cycles, one slot per cycle. Records the first slot matching order_id and the lowest-index free slot.
- UPDATE: one cycle; applies the operation:
  - ADD: fails with BAD if the id is already present or quantity=0. Fails with FULL if there is no free slot. Otherwise writes the lowest free slot and increments count.
  - REDUCE: NOT_FOUND if the id is absent. Otherwise qty -= min(qty, quantity). If the result is 0 the slot is freed and count decrements.
  - CANCEL: NOT_FOUND if the id is absent. Otherwise frees the slot and decrements count.
  - REPLACE: NOT_FOUND if the id is absent. BAD if quantity=0. Otherwise overwrites price and qty in place; the slot is unchanged.
  - Invalid req_type: BAD. The book is unchanged.
  - On any failure the book is unchanged.
- BEST: DEPTH cycles that recompute the best order over the valid slots.
  - Strict comparison: > when IS_BID=1, < when IS_BID=0.
  - Equal prices resolve to the lowest slot index.
  - Empty book: best_valid=0 and best_* =0.
- DONE: ready=1 for exactly one cycle. status, best_* and count update on the same edge that raises ready and hold until the next DONE.
- Latency: ready rises 2*DEPTH+1 edges after the accepting edge. Latency is identical for every req_type and outcome.
- Handshake:
  - The requester drops valid at or after the ready edge.
  - Inputs are ignored outside IDLE.
  - If valid is still high in the IDLE cycle after DONE, a new request is accepted; requesters must therefore deassert valid in the ready cycle.
- Arithmetic: prices and quantities are unsigned. count never exceeds DEPTH and never underflows.

Test Plan:
- DEPTH=8, IS_BID=1; reset, then ADD ids 0..7 with price=20*i and qty=0x435365, one at a time -> each request gives status 00 with ready exactly 17 edges after acceptance. Final state: count=8, best id 7, price 140.
- ADD id 8 into the full book -> status 01; count stays 8; best unchanged (id 7).
- ADD id 3 again -> status 11 (duplicate). REDUCE id 40 -> status 10. req_type 111 -> status 11. Book unchanged in all three cases.
- REDUCE id 7 by 0xF -> qty 0x435356, best still id 7. CANCEL id 7 -> count 7, best id 6 price 120. REDUCE id 6 by 0xFFFFFFFF -> slot freed, count 6, best id 5.
- REPLACE id 0 with price 0x3981 -> best id 0, price 0x3981. ADD id 9 at price 0x3981 -> tie resolves to the lower slot index (id 0).
- IS_BID=0 instance with the same ADD sequence -> best id 0, price 0. Assert reset during SCAN -> no ready pulse, count=0, best_valid=0.

Source files
------------

// File: rtl/order_book_param.sv
// Parametrised single-side limit order book. Holds up to DEPTH resting
// orders and publishes the best one: highest price for a bid book, lowest
// price for an ask book. Every request takes the same number of cycles.
// SCAN runs DEPTH cycles, UPDATE one, BEST DEPTH, then DONE pulses ready.
module order_book_param #(
  parameter int DEPTH   = 256,
  parameter int ID_W    = 32,
  parameter int QTY_W   = 32,
  parameter int PRICE_W = 64,
  parameter bit IS_BID  = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid,
  input  logic [ID_W-1:0]            order_id,
  input  logic [QTY_W-1:0]           quantity,
  input  logic [PRICE_W-1:0]         price,
  input  logic [2:0]                 req_type,
  output logic [ID_W-1:0]            best_order_id,
  output logic [QTY_W-1:0]           best_quantity,
  output logic [PRICE_W-1:0]         best_price,
  output logic                       best_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [1:0]                 status,
  output logic                       ready
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [2:0] REQ_ADD     = 3'b100;
  localparam logic [2:0] REQ_REDUCE  = 3'b001;
  localparam logic [2:0] REQ_CANCEL  = 3'b010;
  localparam logic [2:0] REQ_REPLACE = 3'b011;

  localparam logic [1:0] ST_OK        = 2'b00;
  localparam logic [1:0] ST_FULL      = 2'b01;
  localparam logic [1:0] ST_NOT_FOUND = 2'b10;
  localparam logic [1:0] ST_BAD       = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_UPDATE,
    S_BEST,
    S_DONE
  } state_t;

  state_t state, state_next;

  // Slot storage
  logic [DEPTH-1:0]   slot_valid;
  logic [ID_W-1:0]    slot_id    [DEPTH];
  logic [QTY_W-1:0]   slot_qty   [DEPTH];
  logic [PRICE_W-1:0] slot_price [DEPTH];

  // Latched request
  logic [ID_W-1:0]    req_id;
  logic [QTY_W-1:0]   req_qty;
  logic [PRICE_W-1:0] req_price;
  logic [2:0]         req_kind;

  // Walk index shared by SCAN and BEST
  logic [IW-1:0] idx;
  logic          last_slot;

  // SCAN results
  logic          found;
  logic [IW-1:0] match_idx;
  logic          free_found;
  logic [IW-1:0] free_idx;

  // Occupancy and outcome of UPDATE, published at DONE
  logic [CW-1:0] occ;
  logic [1:0]    op_status;

  // Running best candidate during BEST
  logic               cand_valid;
  logic [ID_W-1:0]    cand_id;
  logic [QTY_W-1:0]   cand_qty;
  logic [PRICE_W-1:0] cand_price;
  logic               nxt_valid;
  logic [ID_W-1:0]    nxt_id;
  logic [QTY_W-1:0]   nxt_qty;
  logic [PRICE_W-1:0] nxt_price;

  // UPDATE decode
  logic [1:0]         upd_status;
  logic               upd_write;
  logic               upd_free;
  logic [IW-1:0]      upd_slot;
  logic [QTY_W-1:0]   upd_qty;
  logic [PRICE_W-1:0] upd_price;
  logic               cnt_inc;
  logic               cnt_dec;
  logic [QTY_W-1:0]   cur_qty;

  assign last_slot = (idx == IW'(DEPTH-1));

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so no path leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      S_IDLE:   if (valid) state_next = S_SCAN;
      S_SCAN:   if (last_slot) state_next = S_UPDATE;
      S_UPDATE: state_next = S_BEST;
      S_BEST:   if (last_slot) state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Output decode: ready is high for the single DONE cycle
  always_comb begin
    ready = (state == S_DONE);
  end

  // Operation decode applied during UPDATE
  always_comb begin
    upd_status = ST_OK;
    upd_write  = 1'b0;
    upd_free   = 1'b0;
    upd_slot   = match_idx;
    upd_qty    = req_qty;
    upd_price  = req_price;
    cnt_inc    = 1'b0;
    cnt_dec    = 1'b0;
    cur_qty    = slot_qty[match_idx];
    case (req_kind)
      REQ_ADD: begin
        if (found || req_qty == '0) begin
          upd_status = ST_BAD;
        end else if (!free_found) begin
          upd_status = ST_FULL;
        end else begin
          upd_write = 1'b1;
          upd_slot  = free_idx;
          cnt_inc   = 1'b1;
        end
      end
      REQ_REDUCE: begin
        if (!found) begin
          upd_status = ST_NOT_FOUND;
        end else if (cur_qty <= req_qty) begin
          upd_free = 1'b1;
          cnt_dec  = 1'b1;
        end else begin
          upd_write = 1'b1;
          upd_qty   = cur_qty - req_qty;
          upd_price = slot_price[match_idx];
        end
      end
      REQ_CANCEL: begin
        if (!found) begin
          upd_status = ST_NOT_FOUND;
        end else begin
          upd_free = 1'b1;
          cnt_dec  = 1'b1;
        end
      end
      REQ_REPLACE: begin
        if (!found)              upd_status = ST_NOT_FOUND;
        else if (req_qty == '0)  upd_status = ST_BAD;
        else                     upd_write  = 1'b1;
      end
      default: upd_status = ST_BAD;
    endcase
  end

  // Candidate update for the slot currently visited by BEST
  always_comb begin
    nxt_valid = cand_valid;
    nxt_id    = cand_id;
    nxt_qty   = cand_qty;
    nxt_price = cand_price;
    if (slot_valid[idx] &&
        (!cand_valid ||
         (IS_BID ? (slot_price[idx] > cand_price) : (slot_price[idx] < cand_price)))) begin
      nxt_valid = 1'b1;
      nxt_id    = slot_id[idx];
      nxt_qty   = slot_qty[idx];
      nxt_price = slot_price[idx];
    end
  end

  // Slot valid bits: cleared by reset, written in UPDATE
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_valid <= '0;
    end else if (state == S_UPDATE) begin
      if (upd_write) slot_valid[upd_slot] <= 1'b1;
      if (upd_free)  slot_valid[upd_slot] <= 1'b0;
    end
  end

  // Slot payload written in UPDATE
  always_ff @(posedge clk) begin
    // NOTE: payload arrays have no reset; slot_valid gates every read.
    if (state == S_UPDATE && upd_write) begin
      slot_id[upd_slot]    <= req_id;
      slot_qty[upd_slot]   <= upd_qty;
      slot_price[upd_slot] <= upd_price;
    end
  end

  // Request latch, scan bookkeeping, occupancy, best search and publishing
  always_ff @(posedge clk) begin
    if (reset) begin
      req_id        <= '0;
      req_qty       <= '0;
      req_price     <= '0;
      req_kind      <= '0;
      idx           <= '0;
      found         <= 1'b0;
      match_idx     <= '0;
      free_found    <= 1'b0;
      free_idx      <= '0;
      occ           <= '0;
      op_status     <= ST_OK;
      cand_valid    <= 1'b0;
      cand_id       <= '0;
      cand_qty      <= '0;
      cand_price    <= '0;
      best_order_id <= '0;
      best_quantity <= '0;
      best_price    <= '0;
      best_valid    <= 1'b0;
      count         <= '0;
      status        <= ST_OK;
    end else begin
      case (state)
        S_IDLE: begin
          idx        <= '0;
          found      <= 1'b0;
          match_idx  <= '0;
          free_found <= 1'b0;
          free_idx   <= '0;
          if (valid) begin
            req_id    <= order_id;
            req_qty   <= quantity;
            req_price <= price;
            req_kind  <= req_type;
          end
        end
        S_SCAN: begin
          if (slot_valid[idx] && slot_id[idx] == req_id && !found) begin
            found     <= 1'b1;
            match_idx <= idx;
          end
          if (!slot_valid[idx] && !free_found) begin
            free_found <= 1'b1;
            free_idx   <= idx;
          end
          idx <= last_slot ? '0 : idx + IW'(1);
        end
        S_UPDATE: begin
          op_status  <= upd_status;
          if (cnt_inc)      occ <= occ + CW'(1);
          else if (cnt_dec) occ <= occ - CW'(1);
          cand_valid <= 1'b0;
          cand_id    <= '0;
          cand_qty   <= '0;
          cand_price <= '0;
          idx        <= '0;
        end
        S_BEST: begin
          cand_valid <= nxt_valid;
          cand_id    <= nxt_id;
          cand_qty   <= nxt_qty;
          cand_price <= nxt_price;
          idx        <= last_slot ? '0 : idx + IW'(1);
          if (last_slot) begin
            best_valid    <= nxt_valid;
            best_order_id <= nxt_id;
            best_quantity <= nxt_qty;
            best_price    <= nxt_price;
            count         <= occ;
            status        <= op_status;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_order_book_param.sv
// Bench for order_book_param: a bid book (dut 0) and an ask book (dut 1),
// directed scenarios followed by random traffic. Expected responses come
// from a slot-array reference model and are queued at issue time; a monitor
// pops and compares whenever a DUT pulses ready.
module tb_order_book_param;

  localparam int DEPTH   = 8;
  localparam int ID_W    = 32;
  localparam int QTY_W   = 32;
  localparam int PRICE_W = 64;
  localparam int CW      = $clog2(DEPTH+1);
  localparam int LAT     = 2*DEPTH+1;

  localparam logic [2:0] ADD     = 3'b100;
  localparam logic [2:0] REDUCE  = 3'b001;
  localparam logic [2:0] CANCEL  = 3'b010;
  localparam logic [2:0] REPLACE = 3'b011;

  typedef struct {
    logic [1:0]         status;
    int                 count;
    bit                 bvalid;
    logic [ID_W-1:0]    id;
    logic [QTY_W-1:0]   qty;
    logic [PRICE_W-1:0] price;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset         [2];
  logic               valid         [2];
  logic [ID_W-1:0]    order_id      [2];
  logic [QTY_W-1:0]   quantity      [2];
  logic [PRICE_W-1:0] price         [2];
  logic [2:0]         req_type      [2];
  logic [ID_W-1:0]    best_order_id [2];
  logic [QTY_W-1:0]   best_quantity [2];
  logic [PRICE_W-1:0] best_price    [2];
  logic               best_valid    [2];
  logic [CW-1:0]      count         [2];
  logic [1:0]         status        [2];
  logic               ready         [2];

  order_book_param #(.DEPTH(DEPTH), .ID_W(ID_W), .QTY_W(QTY_W), .PRICE_W(PRICE_W), .IS_BID(1'b1)) dut_bid (
    .clk(clk), .reset(reset[0]), .valid(valid[0]), .order_id(order_id[0]),
    .quantity(quantity[0]), .price(price[0]), .req_type(req_type[0]),
    .best_order_id(best_order_id[0]), .best_quantity(best_quantity[0]),
    .best_price(best_price[0]), .best_valid(best_valid[0]), .count(count[0]),
    .status(status[0]), .ready(ready[0])
  );

  order_book_param #(.DEPTH(DEPTH), .ID_W(ID_W), .QTY_W(QTY_W), .PRICE_W(PRICE_W), .IS_BID(1'b0)) dut_ask (
    .clk(clk), .reset(reset[1]), .valid(valid[1]), .order_id(order_id[1]),
    .quantity(quantity[1]), .price(price[1]), .req_type(req_type[1]),
    .best_order_id(best_order_id[1]), .best_quantity(best_quantity[1]),
    .best_price(best_price[1]), .best_valid(best_valid[1]), .count(count[1]),
    .status(status[1]), .ready(ready[1])
  );

  int checks = 0;
  int errors = 0;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  // Reference model: the book as a plain slot array
  bit                 m_valid [2][DEPTH];
  logic [ID_W-1:0]    m_id    [2][DEPTH];
  logic [QTY_W-1:0]   m_qty   [2][DEPTH];
  logic [PRICE_W-1:0] m_price [2][DEPTH];

  task automatic check(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", name, d, act, exp);
    end
  endtask

  task automatic model_clear(input int d);
    for (int i = 0; i < DEPTH; i++) m_valid[d][i] = 1'b0;
  endtask

  // Apply one request to the model and report the book as it should look afterwards
  task automatic model_apply(input int d, input logic [2:0] t, input logic [ID_W-1:0] id,
                             input logic [QTY_W-1:0] q, input logic [PRICE_W-1:0] p,
                             output exp_t e);
    int hit = -1;
    int fr  = -1;
    int bi  = -1;
    bit is_bid = (d == 0);
    for (int i = 0; i < DEPTH; i++) begin
      if (m_valid[d][i] && m_id[d][i] == id && hit < 0) hit = i;
      if (!m_valid[d][i] && fr < 0) fr = i;
    end
    e.status = 2'b00;
    case (t)
      ADD: begin
        if (hit >= 0 || q == 0) e.status = 2'b11;
        else if (fr < 0)        e.status = 2'b01;
        else begin
          m_valid[d][fr] = 1'b1;
          m_id[d][fr]    = id;
          m_qty[d][fr]   = q;
          m_price[d][fr] = p;
        end
      end
      REDUCE: begin
        if (hit < 0)                  e.status = 2'b10;
        else if (q >= m_qty[d][hit])  m_valid[d][hit] = 1'b0;
        else                          m_qty[d][hit] = m_qty[d][hit] - q;
      end
      CANCEL: begin
        if (hit < 0) e.status = 2'b10;
        else         m_valid[d][hit] = 1'b0;
      end
      REPLACE: begin
        if (hit < 0)     e.status = 2'b10;
        else if (q == 0) e.status = 2'b11;
        else begin
          m_qty[d][hit]   = q;
          m_price[d][hit] = p;
        end
      end
      default: e.status = 2'b11;
    endcase
    e.count = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_valid[d][i]) begin
        e.count++;
        if (bi < 0 || (is_bid ? m_price[d][i] > m_price[d][bi] : m_price[d][i] < m_price[d][bi]))
          bi = i;
      end
    end
    e.bvalid = (bi >= 0);
    e.id     = (bi >= 0) ? m_id[d][bi]    : '0;
    e.qty    = (bi >= 0) ? m_qty[d][bi]   : '0;
    e.price  = (bi >= 0) ? m_price[d][bi] : '0;
  endtask

  // Issue one request, hold valid until ready, and check the latency
  task automatic send(input int d, input logic [2:0] t, input logic [ID_W-1:0] id,
                      input logic [QTY_W-1:0] q, input logic [PRICE_W-1:0] p);
    exp_t e;
    int n;
    model_apply(d, t, id, q, p, e);
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
    @(negedge clk);
    valid[d]    = 1'b1;
    order_id[d] = id;
    quantity[d] = q;
    price[d]    = p;
    req_type[d] = t;
    @(posedge clk);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ready[d] && n < LAT + 20);
    check("latency", d, 64'(n), 64'(LAT));
    valid[d] = 1'b0;
    @(posedge clk);
  endtask

  // Monitor: compare every ready pulse against the oldest queued expectation
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (ready[d]) begin
        if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready dut%0d: ready=1 with no request outstanding", d);
        end else begin
          e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          check("status",     d, 64'(status[d]),        64'(e.status));
          check("count",      d, 64'(count[d]),         64'(e.count));
          check("best_valid", d, 64'(best_valid[d]),    64'(e.bvalid));
          check("best_id",    d, 64'(best_order_id[d]), 64'(e.id));
          check("best_qty",   d, 64'(best_quantity[d]), 64'(e.qty));
          check("best_price", d, best_price[d],         e.price);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]         t;
    logic [QTY_W-1:0]   q;
    logic [PRICE_W-1:0] p;
    int                 d;
    int                 r;
    for (int i = 0; i < 2; i++) begin
      reset[i] = 1'b1; valid[i] = 1'b0; order_id[i] = '0;
      quantity[i] = '0; price[i] = '0; req_type[i] = '0;
      model_clear(i);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    @(negedge clk);
    check("reset_count",      0, 64'(count[0]),         64'd0);
    check("reset_best_valid", 0, 64'(best_valid[0]),    64'd0);
    check("reset_best_price", 0, best_price[0],         64'd0);
    check("reset_best_id",    0, 64'(best_order_id[0]), 64'd0);
    check("reset_status",     0, 64'(status[0]),        64'd0);
    check("reset_ready",      0, 64'(ready[0]),         64'd0);

    // Fill the bid book
    for (int i = 0; i < DEPTH; i++) send(0, ADD, ID_W'(i), 32'h435365, PRICE_W'(20*i));
    check("fill_count",      0, 64'(count[0]),         64'd8);
    check("fill_best_id",    0, 64'(best_order_id[0]), 64'd7);
    check("fill_best_price", 0, best_price[0],         64'd140);

    send(0, ADD, 32'd8, 32'd10, 64'd5);
    check("full_status", 0, 64'(status[0]),        64'd1);
    check("full_best",   0, 64'(best_order_id[0]), 64'd7);
    send(0, ADD, 32'd3, 32'd10, 64'd5);
    check("dup_status", 0, 64'(status[0]), 64'd3);
    send(0, REDUCE, 32'd40, 32'd1, 64'd0);
    check("nf_status", 0, 64'(status[0]), 64'd2);
    send(0, 3'b111, 32'd1, 32'd1, 64'd0);
    check("bad_status", 0, 64'(status[0]), 64'd3);
    check("bad_count",  0, 64'(count[0]),  64'd8);

    send(0, REDUCE, 32'd7, 32'hF, 64'd0);
    check("reduce_qty", 0, 64'(best_quantity[0]), 64'h435356);
    send(0, CANCEL, 32'd7, 32'd0, 64'd0);
    check("cancel_count", 0, 64'(count[0]),         64'd7);
    check("cancel_best",  0, 64'(best_order_id[0]), 64'd6);
    check("cancel_price", 0, best_price[0],         64'd120);
    send(0, REDUCE, 32'd6, 32'hFFFFFFFF, 64'd0);
    check("drain_count", 0, 64'(count[0]),         64'd6);
    check("drain_best",  0, 64'(best_order_id[0]), 64'd5);
    send(0, REPLACE, 32'd0, 32'h100, 64'h3981);
    check("replace_best",  0, 64'(best_order_id[0]), 64'd0);
    check("replace_price", 0, best_price[0],         64'h3981);
    send(0, ADD, 32'd9, 32'd5, 64'h3981);
    check("tie_best", 0, 64'(best_order_id[0]), 64'd0);

    // Ask book with the same fill
    for (int i = 0; i < DEPTH; i++) send(1, ADD, ID_W'(i), 32'h435365, PRICE_W'(20*i));
    check("ask_best_id",    1, 64'(best_order_id[1]), 64'd0);
    check("ask_best_price", 1, best_price[1],         64'd0);

    // Reset in the middle of SCAN: request aborted, book cleared, no ready
    @(negedge clk);
    valid[1] = 1'b1; order_id[1] = 32'd20; quantity[1] = 32'd1;
    price[1] = 64'd1; req_type[1] = CANCEL;
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset[1] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    valid[1] = 1'b0;
    reset[1] = 1'b0;
    model_clear(1);
    repeat (LAT + 5) @(posedge clk);
    #1;
    check("abort_count",      1, 64'(count[1]),      64'd0);
    check("abort_best_valid", 1, 64'(best_valid[1]), 64'd0);

    // Random traffic on both books
    for (int k = 0; k < 120; k++) begin
      d = int'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      if (r < 4)      t = ADD;
      else if (r < 6) t = REDUCE;
      else if (r < 7) t = CANCEL;
      else if (r < 9) t = REPLACE;
      else            t = 3'($urandom_range(0, 7));
      r = int'($urandom_range(0, 7));
      if (r == 0)      q = '0;
      else if (r == 1) q = 32'hFFFFFFFF;
      else             q = QTY_W'($urandom_range(1, 400));
      if ($urandom_range(0, 5) == 0) p = {$urandom, $urandom};
      else                           p = PRICE_W'($urandom_range(0, 15));
      send(d, t, ID_W'($urandom_range(0, 11)), q, p);
    end

    repeat (4) @(posedge clk);
    check("pending_q0", 0, 64'(exp_q0.size()), 64'd0);
    check("pending_q1", 1, 64'(exp_q1.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
